cipher_tx_serializer: RTL and testbench

Downstream stage of the 16-bit modular exponentiation core. It captures each ciphertext word on the core's one-cycle done pulse and buffers it in a small FIFO. It then serializes each word as two 8N1 UART bytes, MSB byte first, on a single TX line to the Flipper host. It decouples exponentiation throughput from the slow serial link and flags dropped words.

---
 rtl/cipher_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_cipher_tx_serializer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_tx_serializer.sv
// cipher_tx_serializer: buffers 16-bit ciphertext words in a small FIFO and
// sends each one as 8N1 UART bytes, MSB byte first.
// Optional build macro CIPHER_TX_SYNC_EN: each word is preceded by a 0xA5 sync byte.
module cipher_tx_serializer #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   result_in,
  input  logic                          result_valid,
  input  logic                          clear_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] TimerReload = TimerW'(CLKS_PER_BIT - 1);
`ifdef CIPHER_TX_SYNC_EN
  localparam int unsigned BytesPerWord = 3;
`else
  localparam int unsigned BytesPerWord = 2;
`endif
  localparam int unsigned ByteIdxW = $clog2(BytesPerWord);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(BytesPerWord - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q;
  logic [15:0]           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [15:0]           word_q;
  logic [ByteIdxW-1:0]   byte_idx_q;
  logic [2:0]            bit_idx_q;
  logic [TimerW-1:0]     timer_q;
  logic                  tx_q;
  logic                  overflow_q;
  logic                  push, drop, pop;
  logic [7:0]            cur_byte;

  // Fullness is judged before any same-cycle pop, so a full FIFO always rejects.
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign push       = result_valid & ~fifo_full;
  assign drop       = result_valid & fifo_full;
  assign pop        = (state_q == StIdle) & (count_q != '0);
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) | (count_q != '0);
  assign tx         = tx_q;
  assign overflow   = overflow_q;

  // Select the byte currently being shifted out.
  always_comb begin
    cur_byte = word_q[15:8];
`ifdef CIPHER_TX_SYNC_EN
    unique case (byte_idx_q)
      2'd0:    cur_byte = 8'hA5;
      2'd1:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
`else
    if (byte_idx_q[0]) cur_byte = word_q[7:0];
`endif
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= result_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow; a drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)          overflow_q <= 1'b0;
    else if (drop)      overflow_q <= 1'b1;
    else if (clear_ovf) overflow_q <= 1'b0;
  end

  // UART transmit FSM; tx is registered from the current state so it lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      timer_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            word_q     <= mem_q[rd_ptr_q];
            byte_idx_q <= '0;
            timer_q    <= TimerReload;
            state_q    <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (timer_q == '0) begin
            timer_q   <= TimerReload;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StData: begin
          tx_q <= cur_byte[bit_idx_q];
          if (timer_q == '0) begin
            timer_q <= TimerReload;
            if (bit_idx_q == 3'd7) state_q <= StStop;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (timer_q == '0) begin
            timer_q <= TimerReload;
            if (byte_idx_q == LastByte) begin
              state_q <= StIdle;
            end else begin
              byte_idx_q <= byte_idx_q + ByteIdxW'(1);
              state_q    <= StStart;
            end
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_tx_serializer.sv
// Bench for cipher_tx_serializer: a UART monitor decodes tx into rx_q, and each
// scenario task compares decoded bytes against the bytes it queued in exp_q.
module tb_cipher_tx_serializer;

  localparam int Cpb = 4;
`ifdef CIPHER_TX_SYNC_EN
  localparam int Bpw = 3;
`else
  localparam int Bpw = 2;
`endif
  localparam int W = Bpw * 10 * Cpb;  // cycles per word
  localparam int P = W + 1;           // back-to-back word period

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] result_in = '0;
  logic        result_valid = 1'b0;
  logic        clear_ovf = 1'b0;
  logic        tx, busy, fifo_full, overflow;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];  // {stop bit, data byte}

  cipher_tx_serializer #(.FIFO_DEPTH(8), .CLKS_PER_BIT(Cpb)) dut (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .clear_ovf(clear_ovf), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // UART receiver sampling mid-bit on falling clock edges.
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % Cpb == Cpb / 2) begin
        if (mon_cnt / Cpb >= 1 && mon_cnt / Cpb <= 8) mon_byte[mon_cnt / Cpb - 1] = tx;
        else if (mon_cnt / Cpb == 9) begin
          rx_q.push_back({tx, mon_byte});
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
`ifdef CIPHER_TX_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0 || fifo_full !== 1'b0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got tx=%b busy=%b cnt=%0d full=%b ovf=%b want 1 0 0 0 0",
               tx, busy, fifo_count, fifo_full, overflow);
    end
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] e;
    logic [8:0] r;
    result_in = 16'h1A2B;
    result_valid = 1'b1;
    push_word(16'h1A2B);
    for (int i = 1; i <= W + 2; i++) begin
      @(negedge clk);
      result_valid = 1'b0;
      if (i == 1) begin
        checks++;
        if (fifo_count !== 4'd1 || tx !== 1'b1) begin
          errors++;
          $display("FAIL single_push got cnt=%0d tx=%b want 1 1", fifo_count, tx);
        end
      end
      if (i == 2) begin
        checks++;
        if (fifo_count !== 4'd0 || busy !== 1'b1 || tx !== 1'b1) begin
          errors++;
          $display("FAIL single_pop got cnt=%0d busy=%b tx=%b want 0 1 1", fifo_count, busy, tx);
        end
      end
      if (i == 3) begin
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL single_start got tx=%b want 0", tx); end
      end
      if (i == W + 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end got %b want 1", busy); end
      end
      if (i == W + 2) begin
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
          errors++;
          $display("FAIL single_done got busy=%b tx=%b want 0 1", busy, tx);
        end
      end
    end
    wait_rx(exp_q.size(), 4 * P, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== {1'b1, e}) begin errors++; $display("FAIL single_byte got %h want %h", r, {1'b1, e}); end
    end
    repeat (2 * Cpb + 4) @(negedge clk);
  endtask

  task automatic test_overflow_fill();
    bit ok;
    logic [7:0] e;
    logic [8:0] r;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 9) begin
        checks++;
        if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", fifo_full); end
      end
      result_valid = 1'b1;
      result_in = 16'(c);
      if (c <= 8) push_word(16'(c));
    end
    @(negedge clk);
    result_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_drop got ovf=%b cnt=%0d want 1 8", overflow, fifo_count);
    end
    wait_rx(exp_q.size(), 12 * P, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== {1'b1, e}) begin errors++; $display("FAIL fill_byte got %h want %h", r, {1'b1, e}); end
    end
    repeat (P) @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL fill_after got ovf=%b extra=%0d want 1 0", overflow, rx_q.size());
    end
  endtask

  task automatic test_clear_ovf();
    bit ok;
    logic [7:0] e;
    logic [8:0] r;
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clear_plain got %b want 0", overflow); end
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      result_valid = 1'b1;
      result_in = 16'h3300 + 16'(c);
      clear_ovf = (c == 9);
      if (c <= 8) push_word(16'h3300 + 16'(c));
    end
    @(negedge clk);
    result_valid = 1'b0;
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL clear_vs_drop got %b want 1", overflow); end
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clear_again got %b want 0", overflow); end
    wait_rx(exp_q.size(), 12 * P, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clear_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== {1'b1, e}) begin errors++; $display("FAIL clear_byte got %h want %h", r, {1'b1, e}); end
    end
    repeat (2 * Cpb + 4) @(negedge clk);
  endtask

  task automatic test_push_pop();
    bit ok;
    bit v;
    logic [7:0] e;
    logic [8:0] r;
    for (int c = 0; c <= 2 * P + 2; c++) begin
      @(negedge clk);
      if (c == P + 1 || c == P + 2) begin
        checks++;
        if (fifo_count !== 4'd7) begin errors++; $display("FAIL pp_at7 c=%0d got %0d want 7", c, fifo_count); end
      end
      if (c == 2 * P + 1) begin
        checks++;
        if (fifo_count !== 4'd8) begin errors++; $display("FAIL pp_at8 got %0d want 8", fifo_count); end
      end
      if (c == 2 * P + 2) begin
        checks++;
        if (fifo_count !== 4'd7 || overflow !== 1'b1) begin
          errors++;
          $display("FAIL pp_full_pop got cnt=%0d ovf=%b want 7 1", fifo_count, overflow);
        end
      end
      v = (c <= 7) || (c == P + 1) || (c == P + 2) || (c == 2 * P + 1);
      result_valid = v;
      result_in = {8'h40 + 8'(c), 8'hB0 + 8'(c)};
      if (v && c != 2 * P + 1) push_word({8'h40 + 8'(c), 8'hB0 + 8'(c)});
    end
    wait_rx(exp_q.size(), 12 * P, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pp_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== {1'b1, e}) begin errors++; $display("FAIL pp_byte got %h want %h", r, {1'b1, e}); end
    end
    repeat (2 * Cpb + 4) @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
  endtask

  task automatic test_reset_midframe();
    localparam int R = 1 + 10 * Cpb + 2 * Cpb + 2;  // inside DATA of the second byte
    bit ok;
    int lows = 0;
    logic [7:0] e;
    logic [8:0] r;
    logic [15:0] words [4];
    words[0] = 16'hFFFF; words[1] = 16'h1111; words[2] = 16'h2222; words[3] = 16'h3333;
`ifdef CIPHER_TX_SYNC_EN
    exp_q.push_back(8'hA5);
`else
    exp_q.push_back(8'hFF);
`endif
    for (int c = 0; c <= R + 1; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (fifo_count !== 4'd3) begin errors++; $display("FAIL mid_queued got %0d want 3", fifo_count); end
      end
      if (c == R + 1) begin
        checks++;
        if (tx !== 1'b1 || fifo_count !== 4'd0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset got tx=%b cnt=%0d busy=%b want 1 0 0", tx, fifo_count, busy);
        end
      end
      result_valid = (c <= 3);
      result_in = (c <= 3) ? words[c] : 16'h0;
      reset = (c >= R);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet got lows=%0d busy=%b want 0 0", lows, busy);
    end
    wait_rx(1, 4, ok);
    checks++;
    if (!ok || rx_q.size() != 1) begin
      errors++;
      $display("FAIL mid_count got %0d bytes want 1", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== {1'b1, e}) begin errors++; $display("FAIL mid_byte got %h want %h", r, {1'b1, e}); end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e;
    logic [8:0] r;
    result_in = 16'h1234;
    result_valid = 1'b1;
    push_word(16'h1234);
    @(negedge clk);
    result_in = 16'h5678;
    push_word(16'h5678);
    for (int i = 2; i <= P + 3; i++) begin
      @(negedge clk);
      result_valid = 1'b0;
      if (i == 3) begin
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL b2b_first_start got tx=%b want 0", tx); end
      end
      if (i == P + 2) begin
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap got tx=%b busy=%b want 1 1", tx, busy);
        end
      end
      if (i == P + 3) begin
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL b2b_second_start got tx=%b want 0", tx); end
      end
    end
    wait_rx(exp_q.size(), 3 * P, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== {1'b1, e}) begin errors++; $display("FAIL b2b_byte got %h want %h", r, {1'b1, e}); end
    end
    repeat (2 * Cpb + 4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow_fill();
    test_clear_ovf();
    test_push_pop();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
